sad_rca_sequencer: RTL and testbench

//  Multicycle SAD controller that time-shares one ripple_carry_adder (width ACC_W) for three jobs:

---
 rtl/sad_rca_sequencer.sv | 155 +++++++++++++++
 tb/tb_sad_rca_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sad_rca_sequencer.sv
// rtl/sad_rca_sequencer.sv - block SAD controller time-sharing one ripple-carry adder
// Optional build macro SAD_SAT_EN: saturating (sticky all-ones) accumulation instead of modulo wrap.

module ripple_carry_adder #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module sad_rca_sequencer #(
    parameter int PIX_W = 8,
    parameter int BLK_N = 16,
    parameter int ACC_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    input  logic [PIX_W-1:0] i_pix_a,
    input  logic [PIX_W-1:0] i_pix_b,
    output logic             o_sad_valid,
    input  logic             i_sad_ready,
    output logic [ACC_W-1:0] o_sad,
    output logic             o_busy
);
    localparam int CNT_W = (BLK_N > 1) ? $clog2(BLK_N) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_PIX, SUB, NEG, ACC, DONE} state_t;

    state_t           state;
    logic [1:0]       rst_sync;
    logic             rst_n_int;
    logic [ACC_W-1:0] acc, a_q, b_q, d_q;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] add_a, add_b, add_sum, acc_next;
    logic             add_cin, add_cout;

    // Reset asserts immediately but releases two clocks after i_rst_n rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            SUB: begin add_a = a_q; add_b = ~b_q; add_cin = 1'b1; end
            NEG: begin add_b = ~d_q; add_cin = 1'b1; end
            ACC: begin add_a = acc; add_b = d_q; end
            default: ;
        endcase
    end

    ripple_carry_adder #(.W(ACC_W)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef SAD_SAT_EN
    logic sat_q;
    assign acc_next = (sat_q || add_cout) ? '1 : add_sum;
`else
    assign acc_next = add_sum;
`endif

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            o_sad       <= '0;
            o_pix_ready <= 1'b0;
            o_sad_valid <= 1'b0;
            o_busy      <= 1'b0;
`ifdef SAD_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    acc         <= '0;
                    cnt         <= '0;
                    o_pix_ready <= 1'b1;
                    o_busy      <= 1'b1;
                    state       <= WAIT_PIX;
`ifdef SAD_SAT_EN
                    sat_q       <= 1'b0;
`endif
                end
                WAIT_PIX: if (i_pix_valid) begin
                    a_q         <= ACC_W'(i_pix_a);
                    b_q         <= ACC_W'(i_pix_b);
                    o_pix_ready <= 1'b0;
                    state       <= SUB;
                end
                SUB: begin
                    // Carry-out of a + ~b + 1 is set exactly when a >= b.
                    d_q   <= add_sum;
                    state <= add_cout ? ACC : NEG;
                end
                NEG: begin
                    d_q   <= add_sum;
                    state <= ACC;
                end
                ACC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
`ifdef SAD_SAT_EN
                    if (add_cout) sat_q <= 1'b1;
`endif
                    if (cnt == CNT_W'(BLK_N - 1)) begin
                        o_sad       <= acc_next;
                        o_sad_valid <= 1'b1;
                        state       <= DONE;
                    end else begin
                        o_pix_ready <= 1'b1;
                        state       <= WAIT_PIX;
                    end
                end
                DONE: if (i_sad_ready) begin
                    o_sad_valid <= 1'b0;
                    o_busy      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sad_rca_sequencer.sv
// tb/tb_sad_rca_sequencer.sv - self-checking bench for sad_rca_sequencer (ACC_W=12 and ACC_W=10 instances)
module tb_sad_rca_sequencer;
    localparam int BLK_N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        sad_ready = 1'b0;
    logic [7:0]  pa = '0;
    logic [7:0]  pb = '0;
    logic        pix_ready, sad_valid, busy;
    logic [11:0] sad;
    logic        pix_ready2, sad_valid2, busy2;
    logic [9:0]  sad2;

    always #5 clk = ~clk;

    sad_rca_sequencer #(.PIX_W(8), .BLK_N(BLK_N), .ACC_W(12)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pix_valid(pix_valid),
        .o_pix_ready(pix_ready), .i_pix_a(pa), .i_pix_b(pb), .o_sad_valid(sad_valid),
        .i_sad_ready(sad_ready), .o_sad(sad), .o_busy(busy)
    );

    sad_rca_sequencer #(.PIX_W(8), .BLK_N(BLK_N), .ACC_W(10)) dut10 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pix_valid(pix_valid),
        .o_pix_ready(pix_ready2), .i_pix_a(pa), .i_pix_b(pb), .o_sad_valid(sad_valid2),
        .i_sad_ready(sad_ready), .o_sad(sad2), .o_busy(busy2)
    );

    typedef struct {
        logic [7:0] a0, b0, a1, b1;
        bit         stall;
        int         exp_sad;
        int         exp_cyc;
    } vec_t;

    typedef struct {
        int sad;
        int sad2;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference for the 10-bit accumulator: a true sum above 1023 means a carry occurred.
    function automatic int model_sad10(input int s);
`ifdef SAD_SAT_EN
        return (s > 1023) ? 1023 : s;
`else
        return s % 1024;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_block(input vec_t v, input int stop_after, output int cyc);
        int   i;
        exp_t e;
        i      = 0;
        e.sad  = v.exp_sad;
        e.sad2 = model_sad10(v.exp_sad);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        while (!sad_valid && cyc < 200 && !(stop_after >= 0 && i >= stop_after)) begin
            bit hs;
            if (i < BLK_N) begin
                pa = (i % 2 == 1) ? v.a1 : v.a0;
                pb = (i % 2 == 1) ? v.b1 : v.b0;
                pix_valid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            hs = pix_ready && pix_valid;
            @(posedge clk);
            cyc++;
            if (hs) i++;
            @(negedge clk);
        end
        pix_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int cyc, input int exp_cyc);
        exp_t e;
        chk({tag, " sad_valid"}, int'(sad_valid), 1);
        chk({tag, " sad_valid10"}, int'(sad_valid2), 1);
        chk({tag, " pix_ready_in_done"}, int'(pix_ready), 0);
        if (exp_cyc > 0) chk({tag, " cycles"}, cyc, exp_cyc);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, " sad"}, int'(sad), e.sad);
            chk({tag, " sad10"}, int'(sad2), e.sad2);
        end
    endtask

    task automatic release_sad(input string tag, input int exp_sad);
        sad_ready = 1'b1;
        @(negedge clk);
        sad_ready = 1'b0;
        chk({tag, " valid_dropped"}, int'(sad_valid), 0);
        chk({tag, " idle_busy"}, int'(busy), 0);
        chk({tag, " sad_kept"}, int'(sad), exp_sad);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        vecs[0] = '{8'd200, 8'd55,  8'd200, 8'd55,  1'b0, 2320, 48};
        vecs[1] = '{8'd10,  8'd250, 8'd10,  8'd250, 1'b0, 3840, 64};
        vecs[2] = '{8'd0,   8'd255, 8'd255, 8'd0,   1'b0, 4080, 56};
        vecs[3] = '{8'h80,  8'h80,  8'h80,  8'h80,  1'b0, 0,    48};
        vecs[4] = '{8'd255, 8'd0,   8'd255, 8'd0,   1'b0, 4080, 48};
        vecs[5] = '{8'd7,   8'd100, 8'd90,  8'd3,   1'b1, 1440, 0};
        vecs[6] = '{8'd3,   8'd1,   8'd3,   8'd1,   1'b0, 32,   48};

        #1;
        chk("reset pix_ready", int'(pix_ready), 0);
        chk("reset sad_valid", int'(sad_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset sad", int'(sad), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle busy", int'(busy), 0);

        for (int k = 0; k < 7; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            drive_block(vecs[k], -1, cyc);
            check_result(tag, cyc, vecs[k].exp_cyc);
            release_sad(tag, vecs[k].exp_sad);
        end

        // DONE holds its output under backpressure and ignores start pulses.
        drive_block(vecs[0], -1, cyc);
        check_result("hold", cyc, vecs[0].exp_cyc);
        for (int k = 0; k < 10; k++) begin
            start = k[0];
            @(negedge clk);
            chk("hold sad_valid", int'(sad_valid), 1);
            chk("hold sad", int'(sad), 2320);
            chk("hold pix_ready", int'(pix_ready), 0);
        end
        start = 1'b1;
        sad_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sad_ready = 1'b0;
        chk("release+start valid", int'(sad_valid), 0);
        chk("release+start busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        chk("no restart busy", int'(busy), 0);
        chk("no restart pix_ready", int'(pix_ready), 0);

        // Reset after five pairs: everything clears at once, then a fresh block.
        drive_block(vecs[6], 5, cyc);
        void'(sb.pop_back());
        chk("pre-reset busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset pix_ready", int'(pix_ready), 0);
        chk("midreset sad_valid", int'(sad_valid), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset sad", int'(sad), 0);
        chk("midreset busy10", int'(busy2), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        drive_block(vecs[6], -1, cyc);
        check_result("after_reset", cyc, 48);
        release_sad("after_reset", 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
